// File: rtl/activity_led_bank.sv
// Multi-channel activity LED driver: each channel stretches or blinks its LED on input
// transitions, timed by one shared 1 ms prescaler. Output polarity is set per LED.
module activity_led_bank #(
  parameter int                  CHANNELS = 4,
  parameter int                  CLK_MHZ  = 50,
  parameter logic [CHANNELS-1:0] OUT_INV  = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] signal,
  input  logic [15:0]         hold_ms,
  input  logic [CHANNELS-1:0] mode,
  output logic [CHANNELS-1:0] flash
);

  localparam int            TICK_CYC = CLK_MHZ * 1000;
  localparam int            PW       = $clog2(TICK_CYC);
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ON    = 2'd1,
    ST_BLINK = 2'd2
  } state_e;

  logic [PW-1:0]              presc_q, presc_d;
  logic                       tick;
  logic [CHANNELS-1:0]        s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [CHANNELS-1:0]        edge_det;
  state_e                     state_q [CHANNELS];
  state_e                     state_d [CHANNELS];
  logic [CHANNELS-1:0][15:0]  cnt_q, cnt_d;
  logic [CHANNELS-1:0][15:0]  hold_q, hold_d;
  logic [CHANNELS-1:0][2:0]   tog_q, tog_d;
  logic [CHANNELS-1:0]        led_q, led_d;
  logic [CHANNELS-1:0]        flash_q, flash_d;

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    if (v == 3'd7) begin
      return 3'd7;
    end else begin
      return v + 3'd1;
    end
  endfunction

  // Shared 1 ms prescaler and the synchroniser / transition detector chain
  always_comb begin
    tick = (presc_q == PRE_MAX);
    if (tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
    s1_d     = signal;
    s2_d     = s1_q;
    s3_d     = s2_q;
    edge_det = s2_q ^ s3_q;
  end

  // Per-channel state machines; a transition always takes priority over the tick.
  // cnt doubles as the blink phase counter, hold keeps the value latched at load time.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    tog_d   = tog_q;
    led_d   = led_q;
    for (int i = 0; i < CHANNELS; i++) begin
      case (state_q[i])
        ST_IDLE: begin
          if (edge_det[i] && (hold_ms != 16'd0)) begin
            state_d[i] = mode[i] ? ST_BLINK : ST_ON;
            cnt_d[i]   = hold_ms;
            hold_d[i]  = hold_ms;
            tog_d[i]   = 3'd0;
            led_d[i]   = 1'b1;
          end else begin
            led_d[i] = 1'b0;
          end
        end
        ST_ON: begin
          if (edge_det[i]) begin
            // A zero hold_ms must not truncate a running pulse
            if (hold_ms != 16'd0) begin
              cnt_d[i]  = hold_ms;
              hold_d[i] = hold_ms;
            end else begin
              cnt_d[i] = hold_q[i];
            end
          end else if (tick) begin
            if (cnt_q[i] <= 16'd1) begin
              state_d[i] = ST_IDLE;
              cnt_d[i]   = 16'd0;
              led_d[i]   = 1'b0;
            end else begin
              cnt_d[i] = cnt_q[i] - 16'd1;
            end
          end else begin
            led_d[i] = 1'b1;
          end
        end
        ST_BLINK: begin
          if (edge_det[i]) begin
            tog_d[i] = 3'd0;
          end else if (tick) begin
            if (cnt_q[i] <= 16'd1) begin
              tog_d[i] = sat_inc(tog_q[i]);
              // Only stop on a toggle that turns the LED off
              if (led_q[i] && (sat_inc(tog_q[i]) >= 3'd4)) begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = 16'd0;
                led_d[i]   = 1'b0;
              end else begin
                led_d[i] = ~led_q[i];
                cnt_d[i] = hold_q[i];
              end
            end else begin
              cnt_d[i] = cnt_q[i] - 16'd1;
            end
          end else begin
            led_d[i] = led_q[i];
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          led_d[i]   = 1'b0;
        end
      endcase
    end
    flash_d = led_d ^ OUT_INV;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      tog_q   <= '0;
      led_q   <= '0;
      flash_q <= OUT_INV;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= ST_IDLE;
      end
    end else begin
      presc_q <= presc_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      tog_q   <= tog_d;
      led_q   <= led_d;
      flash_q <= flash_d;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  assign flash = flash_q;

endmodule

// File: tb/tb_activity_led_bank.sv
// Directed bench for activity_led_bank at CLK_MHZ=1 (tick every 1000 clk), 4 channels,
// LED 3 active-low. Cycle numbers count clk edges since the last reset edge.
module tb_activity_led_bank;

  localparam logic [3:0] INV = 4'b1000;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic [3:0]  signal  = 4'b0000;
  logic [3:0]  mode    = 4'b0000;
  logic [15:0] hold_ms = 16'd0;
  logic [3:0]  flash;

  int cyc     = 0;
  int err_cnt = 0;
  int chk_cnt = 0;
  int flag;
  int ntog;
  int tchg [8];
  logic prev;

  activity_led_bank #(
    .CHANNELS (4),
    .CLK_MHZ  (1),
    .OUT_INV  (INV)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .signal  (signal),
    .hold_ms (hold_ms),
    .mode    (mode),
    .flash   (flash)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int n);
    int guard = 0;
    while (cyc < n && guard < 100000) begin
      step();
      guard++;
    end
    if (cyc < n) chk("go_to_timeout", cyc, n);
  endtask

  // Reset for 5 edges with a busy input, then release with the given input value
  task automatic do_reset(input logic [3:0] sig_at_release);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      signal = 4'($urandom);
      step();
      chk("rst_flash", flash, INV);
    end
    signal = sig_at_release;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // First tick position and input-to-LED latency
    do_reset(4'b0000);
    hold_ms = 16'd1;
    mode    = 4'b0000;
    go_to(5);    signal[0] = 1'b1;
    go_to(7);    chk("lat_pre", flash, 4'b1000);
    go_to(8);    chk("lat_rise", flash, 4'b1001);
    go_to(999);  chk("tick_pre", flash, 4'b1001);
    go_to(1000); chk("tick_first", flash, 4'b1000);

    // Stretch, hold 3, single edge
    do_reset(4'b0000);
    hold_ms = 16'd3;
    go_to(10);   signal[0] = 1'b1;
    go_to(13);   chk("s3_rise", flash[0], 1'b1);
    go_to(2999); chk("s3_hold", flash[0], 1'b1);
    go_to(3000); chk("s3_fall", flash[0], 1'b0);
    flag = 0;
    while (cyc < 5000) begin
      step();
      if (flash[0]) flag = 1;
    end
    chk("s3_relit", flag, 0);

    // Retrigger every 1500 cycles, 10 edges, last at 18500
    flag = 0;
    while (cyc < 20999) begin
      if (cyc <= 18500 && ((cyc - 5000) % 1500) == 0) signal[0] = ~signal[0];
      step();
      if (cyc >= 5003 && !flash[0]) flag = 1;
    end
    chk("rt_gap", flag, 0);
    go_to(21000); chk("rt_fall", flash[0], 1'b0);

    // Blink, hold 2: lit at 13, toggles at 2000..10000, off for good after the 5th
    do_reset(4'b0000);
    hold_ms = 16'd2;
    mode    = 4'b0010;
    go_to(10); signal[1] = 1'b1;
    ntog = 0;
    prev = 1'b0;
    while (cyc < 14000) begin
      step();
      if (flash[1] != prev) begin
        if (ntog < 8) tchg[ntog] = cyc;
        ntog++;
        prev = flash[1];
      end
    end
    chk("bl_changes", ntog, 6);
    chk("bl_first", tchg[0], 13);
    for (int k = 1; k < 6; k++) chk("bl_time", tchg[k], 2000 * k);
    chk("bl_final", flash[1], 1'b0);
    signal[1] = 1'b0;
    go_to(14002); chk("bl_idle", flash[1], 1'b0);
    go_to(14003); chk("bl_restart", flash[1], 1'b1);

    // Inverted LED 3, then hold_ms = 0 behaviour
    do_reset(4'b0000);
    mode = 4'b0000;
    go_to(5);    chk("inv_idle", flash, 4'b1000);
    hold_ms = 16'd1;
    go_to(10);   signal[3] = 1'b1;
    go_to(13);   chk("inv_pulse", flash, 4'b0000);
    go_to(999);  chk("inv_hold", flash, 4'b0000);
    go_to(1000); chk("inv_end", flash, 4'b1000);
    hold_ms = 16'd0;
    go_to(1100); signal = ~signal;
    flag = 0;
    while (cyc < 2500) begin
      step();
      if (flash != 4'b1000) flag = 1;
    end
    chk("h0_ignore", flag, 0);
    hold_ms = 16'd2;
    signal[0] = ~signal[0];
    go_to(2600); hold_ms = 16'd0;
    go_to(2700); signal[0] = ~signal[0];
    go_to(3999); chk("h0_keep", flash, 4'b1001);
    go_to(4000); chk("h0_end", flash, 4'b1000);

    // Edge coinciding with the terminal tick of ch2, then reset mid-ON
    do_reset(4'b0000);
    hold_ms = 16'd1;
    go_to(10); signal[2] = 1'b1;
    flag = 0;
    while (cyc < 1999) begin
      if (cyc == 997) signal[2] = 1'b0;
      step();
      if (cyc >= 13 && !flash[2]) flag = 1;
    end
    chk("tt_gap", flag, 0);
    go_to(2000); chk("tt_fall", flash, 4'b1000);
    go_to(2100); signal[2] = 1'b1;
    go_to(2103); chk("mo_on", flash, 4'b1100);
    go_to(2200);
    do_reset(4'b0100);
    go_to(2); chk("rel_pre", flash, 4'b1000);
    go_to(3); chk("rel_edge", flash, 4'b1100);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
